// File: rtl/motor_mix_generator.sv
// Quad-rotor mixer: throttle + centred pitch/roll/yaw -> four saturated motor duty values.
// Latency: 3 cycles from the in_valid sample to out_valid; throughput one sample per cycle.
// Backpressure: none; a sample is accepted on every in_valid cycle and results are never stalled.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   arm               - 0 forces all motor outputs to 0 (sampled in the output stage)
//   in_valid          - one-cycle strobe qualifying the four command inputs
//   throttle_offset   - unsigned base throttle
//   pitch/roll/yaw_offset - unsigned attitude commands centred on CENTER, clamped to FULL
//   motor_1..4_offset - registered motor duty values, held between valid samples
//   out_valid         - one-cycle strobe marking new motor values
//
// Optional feature: define MOTOR_MIX_SLEW_EN to limit each output's change per
// valid sample to +/-SLEW_STEP. The output registers double as the slew history.
module motor_mix_generator #(
    parameter int WIDTH     = 8,
    parameter int CENTER    = 20,
    parameter int FULL      = 40,
    parameter int SLEW_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] throttle_offset,
    input  logic [WIDTH-1:0] pitch_offset,
    input  logic [WIDTH-1:0] roll_offset,
    input  logic [WIDTH-1:0] yaw_offset,
    output logic [WIDTH-1:0] motor_1_offset,
    output logic [WIDTH-1:0] motor_2_offset,
    output logic [WIDTH-1:0] motor_3_offset,
    output logic [WIDTH-1:0] motor_4_offset,
    output logic             out_valid
);

    // Deviation width: one extra bit for sign, one for headroom.
    localparam int DW = WIDTH + 2;
    // Mix width: throttle plus three half-deviations cannot exceed this.
    localparam int MW = WIDTH + 3;

    localparam logic [WIDTH-1:0]        FULL_V   = WIDTH'(FULL);
    localparam logic signed [DW-1:0]    CENTER_S = DW'(CENTER);
    localparam logic signed [MW-1:0]    MAX_S    = $signed({3'b000, {WIDTH{1'b1}}});
    localparam logic signed [DW-1:0]    STEP_S   = DW'(SLEW_STEP);
    localparam logic [WIDTH-1:0]        STEP_V   = WIDTH'(SLEW_STEP);

    // Clamp to FULL, centre, then halve. The arithmetic shift floors, so -1 -> -1.
    function automatic logic signed [DW-1:0] half_dev(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0]     c;
        logic signed [DW-1:0] d;
        c = (a > FULL_V) ? FULL_V : a;
        d = $signed({2'b00, c}) - CENTER_S;
        return d >>> 1;
    endfunction

    function automatic logic signed [MW-1:0] sx(input logic signed [DW-1:0] h);
        return {h[DW-1], h};
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [MW-1:0] m);
        if (m < 0)
            return '0;
        else if (m > MAX_S)
            return '1;
        else
            return m[WIDTH-1:0];
    endfunction

    // Move prev toward target by at most STEP. Neither branch can overflow because
    // the stepped value never passes the in-range target.
    function automatic logic [WIDTH-1:0] slew_limit(input logic [WIDTH-1:0] target,
                                                    input logic [WIDTH-1:0] prev);
        logic signed [DW-1:0] diff;
        diff = $signed({2'b00, target}) - $signed({2'b00, prev});
        if (diff > STEP_S)
            return prev + STEP_V;
        else if (diff < -STEP_S)
            return prev - STEP_V;
        else
            return target;
    endfunction

    // Stage 1: throttle and halved deviations
    logic                    v1;
    logic [WIDTH-1:0]        t1;
    logic signed [DW-1:0]    hp, hr, hy;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
        end
        // Data registers need no reset; v1 qualifies them.
        t1 <= throttle_offset;
        hp <= half_dev(pitch_offset);
        hr <= half_dev(roll_offset);
        hy <= half_dev(yaw_offset);
    end

    // Stage 2: signed mix
    logic                    v2;
    logic signed [MW-1:0]    m1, m2, m3, m4;
    logic signed [MW-1:0]    t_ext;

    assign t_ext = $signed({3'b000, t1});

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
        end
        m1 <= t_ext - sx(hp) + sx(hr) + sx(hy);
        m2 <= t_ext + sx(hp) - sx(hr) + sx(hy);
        m3 <= t_ext - sx(hp) - sx(hr) - sx(hy);
        m4 <= t_ext + sx(hp) + sx(hr) - sx(hy);
    end

    // Stage 3: saturate, arm gate, optional slew; outputs hold between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            motor_1_offset <= '0;
            motor_2_offset <= '0;
            motor_3_offset <= '0;
            motor_4_offset <= '0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                if (!arm) begin
                    // Disarm is immediate; it deliberately bypasses the slew limit.
                    motor_1_offset <= '0;
                    motor_2_offset <= '0;
                    motor_3_offset <= '0;
                    motor_4_offset <= '0;
                end else begin
`ifdef MOTOR_MIX_SLEW_EN
                    motor_1_offset <= slew_limit(sat(m1), motor_1_offset);
                    motor_2_offset <= slew_limit(sat(m2), motor_2_offset);
                    motor_3_offset <= slew_limit(sat(m3), motor_3_offset);
                    motor_4_offset <= slew_limit(sat(m4), motor_4_offset);
`else
                    motor_1_offset <= sat(m1);
                    motor_2_offset <= sat(m2);
                    motor_3_offset <= sat(m3);
                    motor_4_offset <= sat(m4);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_mix_generator.sv
module tb_motor_mix_generator;

    localparam int CENTER = 20;
    localparam int FULL   = 40;
    localparam int STEP   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arm = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] thr = '0, pit = '0, rol = '0, yaw = '0;
    logic [7:0] mo1, mo2, mo3, mo4;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motor_mix_generator #(
        .WIDTH(8), .CENTER(CENTER), .FULL(FULL), .SLEW_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid),
        .throttle_offset(thr), .pitch_offset(pit), .roll_offset(rol), .yaw_offset(yaw),
        .motor_1_offset(mo1), .motor_2_offset(mo2), .motor_3_offset(mo3), .motor_4_offset(mo4),
        .out_valid(out_valid)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int t;
        int p;
        int r;
        int y;
        int due;
    } samp_t;

    samp_t q[$];
    samp_t s;
    int    cyc = 0;
    int    em[4] = '{0, 0, 0, 0};
    bit    ev = 1'b0;

    function automatic int half_floor(int d);
        if (d >= 0) return d / 2;
        return -((1 - d) / 2);
    endfunction

    function automatic int dev(int a);
        int c;
        c = (a > FULL) ? FULL : a;
        return half_floor(c - CENTER);
    endfunction

    // A sample seen at edge N loads the outputs at edge N+2 (the third register).
    always @(posedge clk) begin
        int hp, hr, hy, tgt, d;
        int mix[4];
        if (rst) begin
            q.delete();
            em = '{0, 0, 0, 0};
            ev = 1'b0;
        end else begin
            ev = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                s  = q.pop_front();
                hp = dev(s.p);
                hr = dev(s.r);
                hy = dev(s.y);
                mix[0] = s.t - hp + hr + hy;
                mix[1] = s.t + hp - hr + hy;
                mix[2] = s.t - hp - hr - hy;
                mix[3] = s.t + hp + hr - hy;
                for (int i = 0; i < 4; i++) begin
                    tgt = mix[i] < 0 ? 0 : (mix[i] > 255 ? 255 : mix[i]);
                    if (!arm) begin
                        em[i] = 0;
                    end else begin
`ifdef MOTOR_MIX_SLEW_EN
                        d = tgt - em[i];
                        if (d > STEP)  d = STEP;
                        if (d < -STEP) d = -STEP;
                        em[i] = em[i] + d;
`else
                        d = 0;
                        em[i] = tgt + d;
`endif
                    end
                end
                ev = 1'b1;
            end
            if (in_valid)
                q.push_back('{int'(thr), int'(pit), int'(rol), int'(yaw), cyc + 2});
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    // Drive one sample for one cycle; returns at the negedge after the output edge.
    task automatic send_wait(input int t, input int p, input int r, input int y);
        @(negedge clk);
        thr = 8'(t); pit = 8'(p); rol = 8'(r); yaw = 8'(y);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; arm = 1'b1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, mo1, mo2, mo3, mo4} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b m=%0d/%0d/%0d/%0d want all 0", out_valid, mo1, mo2, mo3, mo4);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        // No sample was accepted, so nothing may emerge after reset release.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_output k=%0d got %b want 0", k, out_valid);
            end
        end
    endtask

    task automatic test_hover();
        int want;
`ifdef MOTOR_MIX_SLEW_EN
        want = 4;
`else
        want = 100;
`endif
        arm = 1'b1;
        @(negedge clk);
        thr = 8'd100; pit = 8'd20; rol = 8'd20; yaw = 8'd20;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== (k == 3)) begin
                errors++;
                $display("FAIL hover_latency k=%0d got %b want %b", k, out_valid, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if ({mo1, mo2, mo3, mo4} !== {8'(want), 8'(want), 8'(want), 8'(want)}) begin
                    errors++;
                    $display("FAIL hover_value got %0d/%0d/%0d/%0d want %0d", mo1, mo2, mo3, mo4, want);
                end
            end
        end
    endtask

`ifndef MOTOR_MIX_SLEW_EN
    task automatic test_pitch_saturation();
        int tv[5] = '{100, 100, 100, 250, 5};
        int pv[5] = '{40, 0, 60, 0, 0};
        int w13[5] = '{90, 110, 90, 255, 15};
        int w24[5] = '{110, 90, 110, 240, 0};
        arm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_wait(tv[i], pv[i], 20, 20);
            checks++;
            if ({mo1, mo2, mo3, mo4} !== {8'(w13[i]), 8'(w24[i]), 8'(w13[i]), 8'(w24[i])}) begin
                errors++;
                $display("FAIL pitch_sat case=%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                         i, mo1, mo2, mo3, mo4, w13[i], w24[i], w13[i], w24[i]);
            end
        end
    endtask
`endif

    task automatic test_arm();
        arm = 1'b0;
        send_wait(100, 20, 20, 20);
        checks++;
        if ({out_valid, mo1, mo2, mo3, mo4} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL arm_off got v=%b m=%0d/%0d/%0d/%0d want v=1 all 0", out_valid, mo1, mo2, mo3, mo4);
        end
        arm = 1'b1;
`ifdef MOTOR_MIX_SLEW_EN
        for (int i = 1; i <= 3; i++) begin
            send_wait(100, 20, 20, 20);
            checks++;
            if ({mo1, mo2, mo3, mo4} !== {4{8'(4 * i)}}) begin
                errors++;
                $display("FAIL arm_ramp step=%0d got %0d/%0d/%0d/%0d want %0d", i, mo1, mo2, mo3, mo4, 4 * i);
            end
        end
`else
        send_wait(100, 20, 20, 20);
        checks++;
        if ({mo1, mo2, mo3, mo4} !== {4{8'd100}}) begin
            errors++;
            $display("FAIL arm_on got %0d/%0d/%0d/%0d want 100", mo1, mo2, mo3, mo4);
        end
`endif
    endtask

`ifdef MOTOR_MIX_SLEW_EN
    task automatic test_slew();
        int want[3] = '{104, 108, 110};
        arm = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            thr = 8'd100; pit = 8'd20; rol = 8'd20; yaw = 8'd20;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mo1, mo2, mo3, mo4} !== {4{8'd100}}) begin
            errors++;
            $display("FAIL slew_settle got %0d/%0d/%0d/%0d want 100", mo1, mo2, mo3, mo4);
        end
        for (int i = 0; i < 3; i++) begin
            send_wait(110, 20, 20, 20);
            checks++;
            if ({mo1, mo2, mo3, mo4} !== {4{8'(want[i])}}) begin
                errors++;
                $display("FAIL slew_step i=%0d got %0d/%0d/%0d/%0d want %0d", i, mo1, mo2, mo3, mo4, want[i]);
            end
            repeat (3) @(negedge clk);
            checks++;
            if ({out_valid, mo1, mo2, mo3, mo4} !== {1'b0, {4{8'(want[i])}}}) begin
                errors++;
                $display("FAIL slew_hold i=%0d got v=%b m=%0d want v=0 m=%0d", i, out_valid, mo1, want[i]);
            end
        end
    endtask
`endif

    task automatic test_reset_midstream();
        logic [31:0] wv;
        arm = 1'b1;
        @(negedge clk);
        thr = 8'd200; pit = 8'd20; rol = 8'd20; yaw = 8'd20;
        in_valid = 1'b1;
        @(negedge clk);
        thr = 8'd150;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({out_valid, mo1, mo2, mo3, mo4} !== 33'd0) begin
                errors++;
                $display("FAIL midstream_flush k=%0d got v=%b m=%0d/%0d/%0d/%0d want all 0",
                         k, out_valid, mo1, mo2, mo3, mo4);
            end
            @(negedge clk);
        end
        // Back-to-back samples: one result per cycle.
        for (int k = 0; k <= 7; k++) begin
            if (k >= 1) begin
                checks++;
                if (out_valid !== (k >= 3 && k <= 6)) begin
                    errors++;
                    $display("FAIL b2b_valid k=%0d got %b want %b", k, out_valid, (k >= 3 && k <= 6));
                end
                if (k >= 3 && k <= 6) begin
`ifdef MOTOR_MIX_SLEW_EN
                    wv = {4{8'(4 * (k - 2))}};
`else
                    wv = {4{8'(10 * (k - 2))}};
`endif
                    checks++;
                    if ({mo1, mo2, mo3, mo4} !== wv) begin
                        errors++;
                        $display("FAIL b2b_value k=%0d got %h want %h", k, {mo1, mo2, mo3, mo4}, wv);
                    end
                end
            end
            if (k <= 3) begin
                thr = 8'(10 * (k + 1)); pit = 8'd20; rol = 8'd20; yaw = 8'd20;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [32:0] want;
        for (int c = 0; c < 400; c++) begin
            arm      = ($urandom_range(0, 15) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            thr      = 8'($urandom_range(0, 255));
            pit      = 8'($urandom_range(0, 70));
            rol      = 8'($urandom_range(0, 70));
            yaw      = 8'($urandom_range(0, 70));
            @(negedge clk);
            want = {ev, 8'(em[0]), 8'(em[1]), 8'(em[2]), 8'(em[3])};
            checks++;
            if ({out_valid, mo1, mo2, mo3, mo4} !== want) begin
                errors++;
                $display("FAIL random c=%0d got %h want %h", c, {out_valid, mo1, mo2, mo3, mo4}, want);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hover();
`ifndef MOTOR_MIX_SLEW_EN
        test_pitch_saturation();
`endif
        test_arm();
`ifdef MOTOR_MIX_SLEW_EN
        test_slew();
`endif
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
